// File: rtl/sobel_edge_stage_pkg.sv
// Shared constants, state encoding and gradient helpers for the Sobel edge stage.
package sobel_pkg;

  localparam int PIX_W  = 12;
  localparam int GRAD_W = 15;

  localparam logic [PIX_W-1:0] MAX_PIX = 12'd4095;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic logic [GRAD_W-1:0] widen(input logic [PIX_W-1:0] p);
    return GRAD_W'(p);
  endfunction

  // Magnitude of a 15-bit two's-complement gradient; |g| <= 16380 always fits.
  function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
  endfunction

endpackage

// File: rtl/sobel_edge_stage_if.sv
// Pixel-in / magnitude-out valid-ready stream bundle for the Sobel edge stage.
interface sobel_edge_stage_if;
  import sobel_pkg::*;

  logic [PIX_W-1:0] IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic [PIX_W-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;

  modport master (
    output IN_DATA,
    output IN_VALID,
    input  IN_READY,
    input  OUT_DATA,
    input  OUT_VALID,
    output OUT_READY
  );

  modport slave (
    input  IN_DATA,
    input  IN_VALID,
    output IN_READY,
    output OUT_DATA,
    output OUT_VALID,
    input  OUT_READY
  );

endinterface

// File: rtl/sobel_edge_stage_line_buffer.sv
// Two-line buffer indexed by column: taps are the pixels one and two rows above the
// current column, readable in the same cycle as the write that advances them.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  din,
  output logic [PIX_W-1:0]  tap1,
  output logic [PIX_W-1:0]  tap2
);

  logic [PIX_W-1:0] line1 [WIDTH];
  logic [PIX_W-1:0] line2 [WIDTH];

  assign tap1 = line1[addr];
  assign tap2 = line2[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      line1[addr] <= din;
      line2[addr] <= line1[addr];
    end
  end

endmodule

// File: rtl/sobel_edge_stage.sv
// Streaming 3x3 Sobel gradient-magnitude stage with valid/ready backpressure.
// Define SOBEL_THRESHOLD_EN to emit a binary edge map thresholded by THRESH.
module sobel_edge_stage
  import sobel_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int SHIFT  = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [PIX_W-1:0] THRESH,
  output logic             BUSY,
  output logic             DONE,
  sobel_edge_stage_if.slave stream
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  state_t state, state_nx;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             stall;
  logic             accept;
  logic             last_pix;

  logic [PIX_W-1:0] win [3][3];
  logic             mask1;
  logic             v1;
  logic [PIX_W-1:0] tap1, tap2;

  logic [PIX_W-1:0] out_data;
  logic             out_valid;

  assign stall           = out_valid && !stream.OUT_READY;
  assign stream.IN_READY = (state == RUN) && !stall;
  assign accept          = stream.IN_VALID && stream.IN_READY;
  assign last_pix        = (row == ROW_LAST) && (col == COL_LAST);

  assign stream.OUT_DATA  = out_data;
  assign stream.OUT_VALID = out_valid;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    DONE     = 1'b0;
    BUSY     = (state != IDLE);
    case (state)
      IDLE:    if (START) state_nx = RUN;
      RUN:     if (accept && last_pix) state_nx = DRAIN;
      DRAIN: begin
        if (!v1 && !out_valid) begin
          DONE     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET || (state == IDLE && START)) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  sobel_line_buffer #(
    .WIDTH  (WIDTH),
    .ADDR_W (COL_W)
  ) u_line_buffer (
    .clk  (CLK),
    .en   (accept),
    .addr (col),
    .din  (stream.IN_DATA),
    .tap1 (tap1),
    .tap2 (tap2)
  );

  // Stage 1: window slides left; new right column is {row r-2, row r-1, incoming}.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v1    <= 1'b0;
      mask1 <= 1'b0;
      for (int unsigned i = 0; i < 3; i++)
        for (int unsigned j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= tap2;
      win[1][2] <= tap1;
      win[2][2] <= stream.IN_DATA;
      mask1     <= (row < ROW_W'(2)) || (col < COL_W'(2));
      v1        <= 1'b1;
    end else if (!stall) begin
      v1 <= 1'b0;
    end
  end

  logic [GRAD_W-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [GRAD_W-1:0] gx, gy;
  logic [15:0]              mag, shifted;
  logic [PIX_W-1:0]         res, pix_nx;

  // Positive/negative halves stay below 2^14, so the 15-bit difference is exact.
  always_comb begin
    gx_pos  = widen(win[0][2]) + (widen(win[1][2]) << 1) + widen(win[2][2]);
    gx_neg  = widen(win[0][0]) + (widen(win[1][0]) << 1) + widen(win[2][0]);
    gy_pos  = widen(win[2][0]) + (widen(win[2][1]) << 1) + widen(win[2][2]);
    gy_neg  = widen(win[0][0]) + (widen(win[0][1]) << 1) + widen(win[0][2]);
    gx      = $signed(gx_pos - gx_neg);
    gy      = $signed(gy_pos - gy_neg);
    mag     = 16'(abs_grad(gx)) + 16'(abs_grad(gy));
    shifted = mag >> SHIFT;
    res     = (shifted > 16'(MAX_PIX)) ? MAX_PIX : shifted[PIX_W-1:0];
  end

`ifdef SOBEL_THRESHOLD_EN
  always_comb begin
    pix_nx = (!mask1 && (res >= THRESH)) ? MAX_PIX : '0;
  end
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;

  always_comb begin
    pix_nx = mask1 ? '0 : res;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!stall) begin
      out_valid <= v1;
      out_data  <= pix_nx;
    end
  end

endmodule

// File: tb/tb_sobel_edge_stage.sv
// Self-checking bench for sobel_edge_stage on an 8x4 frame against a behavioural model.
module tb_sobel_edge_stage;
  import sobel_pkg::*;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [11:0] THRESH;
  logic        BUSY;
  logic        DONE;

  sobel_edge_stage_if bus ();

  sobel_edge_stage #(
    .WIDTH  (W),
    .HEIGHT (H),
    .SHIFT  (2)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .THRESH (THRESH),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .stream (bus)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  int img [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: Sobel on the stored frame, output k = window with bottom-right at pixel k.
  function automatic int ref_pix(input int k);
    int r, c, gx, gy, mag, res;
    int p [3][3];
    r = k / W;
    c = k % W;
    if (r < 2 || c < 2) return 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = img[(r - 2 + i) * W + (c - 2 + j)];
    gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy  = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    res = mag / 4;
    if (res > 4095) res = 4095;
`ifdef SOBEL_THRESHOLD_EN
    return (res >= int'(THRESH)) ? 4095 : 0;
`else
    return res;
`endif
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: img[k] = 2000;
        1: img[k] = ((k % W) >= 4) ? 1000 : 0;
        2: img[k] = ((k % W) > (k / W)) ? 4095 : 0;
        default: img[k] = int'($urandom_range(0, 4095));
      endcase
    end
  endtask

  // rdy_mode: 0 always ready, 1 five-cycle stall mid-frame, 2 random.
  // abort_at >= 0: pulse START during RUN and return once that many pixels are accepted.
  task automatic run_frame(input int rdy_mode, input bit rnd_valid, input int abort_at);
    int  acc, outs, dones, cyc;
    bit  prev_stall;
    logic [11:0] prev_data;
    acc = 0; outs = 0; dones = 0; cyc = 0; prev_stall = 0; prev_data = '0;
    START = 1'b1;
    @(negedge CLK);
    while (cyc < 2000) begin
      bus.IN_VALID  = (acc < N) && (!rnd_valid || $urandom_range(0, 3) != 0);
      bus.IN_DATA   = (acc < N) ? 12'(img[acc]) : '0;
      case (rdy_mode)
        0:       bus.OUT_READY = 1'b1;
        1:       bus.OUT_READY = !(cyc >= 10 && cyc < 15);
        default: bus.OUT_READY = ($urandom_range(0, 2) != 0);
      endcase
      START = (abort_at >= 0) && (cyc == 5);
      #1;
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.OUT_VALID), 32'd1);
        chk("hold_data", 32'(bus.OUT_DATA), 32'(prev_data));
      end
      if (bus.OUT_VALID && !bus.OUT_READY) chk("stall_in_ready", 32'(bus.IN_READY), 32'd0);
      prev_stall = bus.OUT_VALID && !bus.OUT_READY;
      prev_data  = bus.OUT_DATA;
      if (DONE) dones++;
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (outs < N) chk($sformatf("pix%0d", outs), 32'(bus.OUT_DATA), 32'(ref_pix(outs)));
        outs++;
      end
      if (bus.IN_VALID && bus.IN_READY) acc++;
      @(negedge CLK);
      cyc++;
      if (dones > 0 && !BUSY) break;
      if (abort_at >= 0 && acc == abort_at) break;
    end
    START = 1'b0;
    if (abort_at < 0) begin
      chk("out_count", 32'(outs), 32'(N));
      chk("done_count", 32'(dones), 32'd1);
      chk("busy_after", 32'(BUSY), 32'd0);
    end else begin
      chk("abort_reached", 32'(acc), 32'(abort_at));
      chk("abort_done", 32'(dones), 32'd0);
    end
  endtask

  initial begin
    bit done_seen;
    RESET         = 1'b1;
    START         = 1'b0;
    THRESH        = 12'd800;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = '0;
    bus.OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("rst_out_data", 32'(bus.OUT_DATA), 32'd0);
    chk("rst_in_ready", 32'(bus.IN_READY), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    fill(0); run_frame(0, 1'b0, -1);
    fill(1); run_frame(0, 1'b0, -1);
    fill(2); run_frame(0, 1'b0, -1);
    fill(1); run_frame(1, 1'b0, -1);
    fill(3); run_frame(2, 1'b1, -1);

    fill(3); run_frame(0, 1'b0, 17);
    RESET = 1'b1;
    @(negedge CLK);
    RESET        = 1'b0;
    bus.IN_VALID = 1'b1;
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_out_valid", 32'(bus.OUT_VALID), 32'd0);
    chk("abort_out_data", 32'(bus.OUT_DATA), 32'd0);
    chk("abort_in_ready", 32'(bus.IN_READY), 32'd0);
    done_seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      #1;
      done_seen |= DONE;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("idle_in_ready", 32'(bus.IN_READY), 32'd0);
    bus.IN_VALID = 1'b0;
    @(negedge CLK);

    fill(1); run_frame(0, 1'b0, -1);
    THRESH = 12'd1001;
    fill(1); run_frame(2, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_edge_stage.md
Name: sobel_edge_stage

Overview:
Streaming 3x3 Sobel gradient-magnitude stage directly downstream of the Gaussian smoothing stage. It consumes the 12-bit blurred gray pixel stream in raster order and produces one 12-bit edge-magnitude pixel per accepted input. Its output feeds the SDRAM write FIFO. A valid/ready handshake lets write-FIFO full status stall the stage without data loss.

Parameters:
WIDTH, 320, pixels per line.
HEIGHT, 240, lines per frame.
SHIFT, 2, right shift applied to |Gx|+|Gy| before saturation.

Ports:
CLK  input  1  stage clock (the FIFO-side clock).
RESET  input  1  synchronous, active-high reset.
START  input  1  one-cycle frame-start pulse.
IN_DATA  input  12  blurred pixel.
IN_VALID  input  1  IN_DATA valid.
IN_READY  output  1  stage accepts IN_DATA this cycle.
OUT_DATA  output  12  edge magnitude.
OUT_VALID  output  1  OUT_DATA valid.
OUT_READY  input  1  downstream accepts OUT_DATA (tie to !WR_FULL).
THRESH  input  12  binarisation threshold; used only with the optional feature.
BUSY  output  1  high in RUN or DRAIN.
DONE  output  1  one-cycle pulse when the last output of a frame is accepted.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Reset values: state IDLE; OUT_VALID=0; OUT_DATA=0; IN_READY=0; BUSY=0; DONE=0; row/col counters 0; pipeline valids 0. Line-buffer RAM contents are not cleared.
- Handshakes:
  - Accept = IN_VALID && IN_READY.
  - Output transfer = OUT_VALID && OUT_READY.
  - stall = OUT_VALID && !OUT_READY.
  - IN_READY = (state==RUN) && !stall.
  - OUT_DATA and OUT_VALID hold stable while stalled.
- FSM:
  - IDLE: on START go to RUN and clear the counters.
  - RUN: on the accept of pixel WIDTH*HEIGHT go to DRAIN.
  - DRAIN: once both pipeline valids are 0 (last output transferred), pulse DONE and go to IDLE.
  - START is ignored in RUN and DRAIN.
  - RESET in any state returns to IDLE within 1 cycle. A partial frame is discarded and DONE is not pulsed.
- Counters: col increments on each accept and wraps from WIDTH-1 to 0. row increments on col wrap. The row/col values tagged to a pixel are the values at its accept.
- Stage 1 (on accept):
  - The window shifts left one column.
  - The new right column is {line buffer tap row r-2, tap row r-1, IN_DATA}.
  - IN_DATA is pushed into the two-line buffer.
  - Tag the pixel with mask = (row<2)||(col<2).
  - v1 <= 1. When no accept and no stall, v1 <= 0.
- Stage 2 (when !stall):
  - Gx = (p02+2p12+p22)-(p00+2p10+p20), signed 15-bit.
  - Gy = (p20+2p21+p22)-(p00+2p01+p02), signed 15-bit.
  - mag = |Gx|+|Gy|, unsigned 16-bit.
  - res = min(mag>>SHIFT, 4095).
  - OUT_DATA <= mask ? 0 : res.
  - OUT_VALID <= v1.
- Output geometry: output k corresponds to the window whose bottom-right is input k, i.e. centre (r-1,c-1). Exactly WIDTH*HEIGHT outputs per frame. Rows 0–1 and columns 0–1 are 0. The one-row/one-column offset is accounted for by the write address.
- Latency: 2 cycles from accept to OUT_VALID with OUT_READY held high. Full throughput is 1 pixel/cycle.
- Simultaneous events: an accept and an output transfer in the same cycle are both honoured, with no bubble. OUT_READY dropping while IN_VALID is high freezes both stages and the counters.

Optional Feature:
- Macro: SOBEL_THRESHOLD_EN.
- Defined: stage 2 emits OUT_DATA = (!mask && res>=THRESH) ? 4095 : 0, giving a binary edge map.
- Undefined: THRESH is ignored and OUT_DATA is the saturated magnitude. Latency is identical in both builds.

Decomposition:
- Package sobel_pkg holds:
  - constants PIX_W=12 and GRAD_W=15;
  - the state enum {IDLE, RUN, DRAIN};
  - the max-pixel constant 4095.
- One natural sub-module, sobel_line_buffer: a WIDTH-deep, 2-tap shift line buffer with clock enable, advancing on accept. A replacement for it needs a 1-cycle-aligned tap output.

Test Plan:
- Flat frame (WIDTH=8, HEIGHT=4, all 2000), START, OUT_READY=1 -> 32 outputs all 0; DONE pulses once; BUSY low afterwards.
- Vertical step, same size (cols 0–3 = 0, cols 4–7 = 1000) -> rows 2–3: outputs at col 4 and 5 = 1000, all others 0.
- Diagonal 0/4095 pattern -> every unmasked output with mag>>2 > 4095 reads 4095 (saturation check).
- OUT_READY low for 5 cycles mid-frame -> IN_READY low, OUT_DATA/OUT_VALID stable, no lost or duplicated outputs (count = 32).
- START pulsed during RUN, then RESET asserted at pixel 17 -> START has no effect; after RESET, IDLE, all outputs 0, no DONE; a new START processes a clean frame.
- SOBEL_THRESHOLD_EN, step frame, THRESH=800 -> outputs 4095 at cols 4–5 of rows 2–3, else 0; THRESH=1001 -> all 0.
